vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA timing and test-pattern generator; supersedes the fixed 640x480 top-level.
//  Sits between the board clock and the VGA connector pins.
//  Divides clk down to the pixel rate and runs horizontal/vertical counters from it.
//  Drives sync pulses, the active-video flag, pixel coordinates and a selectable test pattern.
// PARAMETERS
//  CLK_DIV    4    clk cycles per pixel (>=1); 4 gives 25 MHz from 100 MHz
//  H_SYNC     96   hsync width, pixels
//  H_BP       48   h back porch, pixels
//  H_ACTIVE   640  visible pixels per line (multiple of 8)
//  H_FP       16   h front porch, pixels
//  V_SYNC     2    vsync width, lines
//  V_BP       33   v back porch, lines
//  V_ACTIVE   480  visible lines
//  V_FP       10   v front porch, lines
//  SYNC_POL   1    1 = sync asserted high, 0 = sync asserted low
//  CW         12   counter and coordinate width
// PORTS
//  clk          in   1   system clock
//  rst          in   1   async active-high reset
//  mode         in   2   pattern: 0 white, 1 colour bars, 2 checker, 3 black
//  Hsynq        out  1   horizontal sync
//  Vsynq        out  1   vertical sync
//  Red          out  4   red channel
//  Green        out  4   green channel
//  Blue         out  4   blue channel
//  active       out  1   visible-pixel flag, aligned with RGB
//  pix_x        out  CW  x coordinate (0..H_ACTIVE-1) in active, else 0
//  pix_y        out  CW  y coordinate (0..V_ACTIVE-1) in active, else 0
//  frame_start  out  1   one-clk pulse when h=0 and v=0 are entered
//  pix_ce       out  1   pixel-rate strobe, one clk high every CLK_DIV clks
// BEHAVIOUR
//  - Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (default 800); V_TOTAL likewise (default 525).
//  - Region order within each line/frame: sync, back porch, active, front porch.
//  - Divider: runs 0..CLK_DIV-1 on every clk. pix_ce is high when it wraps. CLK_DIV=1 gives pix_ce stuck high.
//  - h_cnt: increments on pix_ce and wraps H_TOTAL-1 -> 0.
//  - v_cnt: increments on the pix_ce where h_cnt wraps, and wraps V_TOTAL-1 -> 0.
//  - Sync levels: Hsynq asserted while h_cnt < H_SYNC; Vsynq asserted while v_cnt < V_SYNC.
//  - Sync polarity: asserted level = SYNC_POL.
//  - Active window:
//      H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE, and
//      V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
//      Default: h 144..783, v 35..514.
//  - Output latency: all outputs are registered, 1 clk after the counter state they reflect.
//  - Output alignment: Hsynq, Vsynq, RGB, active, pix_x and pix_y are mutually aligned.
//  - RGB outside active is forced to 0.
//  - mode sampling: mode is captured into mode_q only at frame start (h_cnt=0, v_cnt=0 on pix_ce).
//  - mid-frame mode changes: ignored until the next frame.
//  - Pattern 0: all channels F.
//  - Pattern 1: 8 vertical bars, each BAR_W = H_ACTIVE/8 px wide.
//      Bar index b (0..7) comes from a bar-width counter cleared at active-line start; no divider.
//      Colour = {R,G,B} = {~b[2],~b[1],~b[0]}, each bit expanded to F/0.
//      Bar 0 is white, bar 7 is black.
//  - Pattern 2: white where pix_x[5]^pix_y[5] = 0, else black (32-px squares).
//  - Pattern 3: all channels 0.
//  - Reset (asserted async, at any time, including mid-line):
//      divider, h_cnt, v_cnt = 0; mode_q = 0.
//      Hsynq, Vsynq = ~SYNC_POL; RGB, active, pix_x, pix_y, frame_start = 0; pix_ce = 0.
//  - After reset release: first pix_ce after CLK_DIV clks; the frame restarts at h=0, v=0 with no partial-line artefacts.
// TESTING
//  T1 defaults, run 2 frames: 800 pix_ce per line; Hsynq high for exactly 96 pix_ce; Vsynq high for 2 lines (1600 pix_ce); frame = 420000 pix_ce.
//  T2 defaults, mode=0: active high for 640 px/line on 480 lines; first active at h=144, v=35; RGB=FFF only while active, 000 elsewhere.
//  T3 mode=1: pix_x 0..79 -> FFF; 80 -> FF0; 559 -> 00F; 560..639 -> 000.
//  T4 mode switched 0->2 at v=200: remainder of frame stays white; next frame shows checker, (0,0)=FFF, (32,0)=000, (32,32)=FFF.
//  T5 rst pulsed at h=400, v=300: all outputs take reset values within the same clk; after release, frame_start fires at first pix_ce.
//  T6 CLK_DIV=1, SYNC_POL=0, H_ACTIVE=8, other timings 2: pix_ce constantly high; Hsynq low for 2 clks per 14-clk line.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing and test-pattern generator
//
// Divides clk to the pixel rate, runs horizontal/vertical counters and
// produces sync pulses, the active-video flag, pixel coordinates and one of
// four test patterns. All outputs are registered one clk after the counter
// state they reflect, so sync, RGB, active and coordinates stay aligned.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   mode         pattern select: 0 white, 1 colour bars, 2 checker, 3 black
//   Hsynq        horizontal sync (asserted level = SYNC_POL)
//   Vsynq        vertical sync (asserted level = SYNC_POL)
//   Red          red channel, 4 bits
//   Green        green channel, 4 bits
//   Blue         blue channel, 4 bits
//   active       visible-pixel flag, aligned with RGB
//   pix_x        x coordinate inside the active window, else 0
//   pix_y        y coordinate inside the active window, else 0
//   frame_start  one-clk pulse on the pixel strobe at h=0, v=0
//   pix_ce       pixel-rate strobe, one clk high every CLK_DIV clks

module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int SYNC_POL = 1,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  output logic          Hsynq,
  output logic          Vsynq,
  output logic [3:0]    Red,
  output logic [3:0]    Green,
  output logic [3:0]    Blue,
  output logic          active,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          pix_ce
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] H_TOTAL_M1 = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_TOTAL_M1 = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_C   = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C   = CW'(V_SYNC);
  localparam logic [CW-1:0] H_START    = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_START_M1 = CW'(H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] H_END      = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_START    = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_END      = CW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CW-1:0] BAR_W_M1   = CW'(BAR_W - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [DIV_W-1:0] div_cnt;
  logic [CW-1:0]    h_cnt;
  logic [CW-1:0]    v_cnt;
  logic [1:0]       mode_q;
  logic [CW-1:0]    bar_px;
  logic [2:0]       bar_idx;

  logic             tick;
  logic             h_sync_c;
  logic             v_sync_c;
  logic             h_act;
  logic             v_act;
  logic             act_c;
  logic [CW-1:0]    x_c;
  logic [CW-1:0]    y_c;
  logic [11:0]      rgb_c;

  // Internal pixel strobe; pix_ce is its registered copy.
  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_TOTAL_M1) begin
        h_cnt <= '0;
        if (v_cnt == V_TOTAL_M1) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + CW'(1);
        end
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // Pattern select only changes on the strobe that leaves h=0, v=0, so a
  // frame is always drawn with a single pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 2'd0;
    end else if (tick && (h_cnt == '0) && (v_cnt == '0)) begin
      mode_q <= mode;
    end
  end

  // Bar position tracks h_cnt: cleared when the line enters the active
  // window, then advances one bar every BAR_W pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_px  <= '0;
      bar_idx <= 3'd0;
    end else if (tick) begin
      if (h_cnt == H_START_M1) begin
        bar_px  <= '0;
        bar_idx <= 3'd0;
      end else if (h_act) begin
        if (bar_px == BAR_W_M1) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + CW'(1);
        end
      end
    end
  end

  assign h_sync_c = (h_cnt < H_SYNC_C);
  assign v_sync_c = (v_cnt < V_SYNC_C);
  assign h_act    = (h_cnt >= H_START) && (h_cnt < H_END);
  assign v_act    = (v_cnt >= V_START) && (v_cnt < V_END);
  assign act_c    = h_act && v_act;
  assign x_c      = h_cnt - H_START;
  assign y_c      = v_cnt - V_START;

  always_comb begin
    rgb_c = 12'h000;
    case (mode_q)
      2'd0:    rgb_c = 12'hFFF;
      2'd1:    rgb_c = {{4{~bar_idx[2]}}, {4{~bar_idx[1]}}, {4{~bar_idx[0]}}};
      2'd2:    rgb_c = (x_c[5] ^ y_c[5]) ? 12'h000 : 12'hFFF;
      default: rgb_c = 12'h000;
    endcase
    if (!act_c) begin
      rgb_c = 12'h000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Hsynq       <= SYNC_OFF;
      Vsynq       <= SYNC_OFF;
      Red         <= 4'h0;
      Green       <= 4'h0;
      Blue        <= 4'h0;
      active      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      pix_ce      <= 1'b0;
    end else begin
      Hsynq       <= h_sync_c ? SYNC_ON : SYNC_OFF;
      Vsynq       <= v_sync_c ? SYNC_ON : SYNC_OFF;
      Red         <= rgb_c[11:8];
      Green       <= rgb_c[7:4];
      Blue        <= rgb_c[3:0];
      active      <= act_c;
      pix_x       <= act_c ? x_c : '0;
      pix_y       <= act_c ? y_c : '0;
      frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      pix_ce      <= tick;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen
module tb_vga_timing_gen;

  localparam int HT = 73;
  localparam int VT = 47;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic [1:0] mode = 2'd0;

  logic hs, vs, act, fs, pce;
  logic [3:0] r, g, b;
  logic [11:0] px, py;

  logic hs2, vs2, act2, fs2, pce2;
  logic [3:0] r2, g2, b2;
  logic [11:0] px2, py2;

  vga_timing_gen #(
    .CLK_DIV(2), .H_SYNC(4), .H_BP(3), .H_ACTIVE(64), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_ACTIVE(40), .V_FP(2), .SYNC_POL(1), .CW(12)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .Hsynq(hs), .Vsynq(vs),
    .Red(r), .Green(g), .Blue(b), .active(act), .pix_x(px), .pix_y(py),
    .frame_start(fs), .pix_ce(pce)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(2), .V_FP(2), .SYNC_POL(0), .CW(12)
  ) dut2 (
    .clk(clk), .rst(rst2), .mode(2'd0), .Hsynq(hs2), .Vsynq(vs2),
    .Red(r2), .Green(g2), .Blue(b2), .active(act2), .pix_x(px2), .pix_y(py2),
    .frame_start(fs2), .pix_ce(pce2)
  );

  initial forever #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int idx;
    logic hs, vs, act, fs;
    logic [11:0] rgb, x, y;
  } exp_t;

  typedef struct {
    int f, x, y;
    logic [11:0] rgb;
  } pt_t;

  exp_t q[$];
  exp_t q2[$];
  int vectors = 0;
  int miscompares = 0;

  // pattern used by each frame: frames 0..3 of the main run, then frame 4
  int fm [5] = '{0, 2, 1, 3, 0};

  pt_t pts [15] = '{
    '{0, 0, 0, 12'hFFF}, '{0, 63, 39, 12'hFFF},
    '{1, 0, 0, 12'hFFF}, '{1, 32, 0, 12'h000}, '{1, 32, 32, 12'hFFF},
    '{1, 31, 31, 12'hFFF}, '{1, 0, 32, 12'h000},
    '{2, 0, 3, 12'hFFF}, '{2, 7, 3, 12'hFFF}, '{2, 8, 3, 12'hFF0},
    '{2, 16, 3, 12'hF0F}, '{2, 55, 3, 12'h00F}, '{2, 56, 3, 12'h000},
    '{2, 63, 39, 12'h000},
    '{3, 10, 10, 12'h000}
  };

  task automatic check(input string name, input int idx, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, got, want);
    end
  endtask

  function automatic exp_t model(input int idx, input int p, input int m);
    exp_t e;
    int h, v, x, y, bi;
    h = p % HT;
    v = p / HT;
    x = h - 7;
    y = v - 5;
    e.idx = idx;
    e.hs  = (h < 4);
    e.vs  = (v < 2);
    e.act = (h >= 7) && (h < 71) && (v >= 5) && (v < 45);
    e.fs  = (p == 0);
    e.x   = e.act ? 12'(x) : 12'd0;
    e.y   = e.act ? 12'(y) : 12'd0;
    e.rgb = 12'h000;
    if (e.act) begin
      case (m)
        0: e.rgb = 12'hFFF;
        1: begin
          bi = x / 8;
          e.rgb = (((bi & 4) != 0) ? 12'h000 : 12'hF00) |
                  (((bi & 2) != 0) ? 12'h000 : 12'h0F0) |
                  (((bi & 1) != 0) ? 12'h000 : 12'h00F);
        end
        2: e.rgb = ((((x / 32) ^ (y / 32)) & 1) != 0) ? 12'h000 : 12'hFFF;
        default: e.rgb = 12'h000;
      endcase
    end
    return e;
  endfunction

  // main monitor: one pixel per pix_ce, popped in order
  initial begin
    int n;
    exp_t e;
    n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n = 0;
      end else if (pce) begin
        check("pix_ce_time", n, cyc, 2 * (n + 1));
        while (q.size() > 0 && q[0].idx == n) begin
          e = q.pop_front();
          check("hsync", n, hs, e.hs);
          check("vsync", n, vs, e.vs);
          check("active", n, act, e.act);
          check("frame_start", n, fs, e.fs);
          check("rgb", n, {r, g, b}, e.rgb);
          check("pix_x", n, px, e.x);
          check("pix_y", n, py, e.y);
        end
        n++;
      end
    end
  end

  // CLK_DIV=1 monitor: one entry every clk after release
  initial begin
    int k;
    exp_t e;
    k = 0;
    forever begin
      @(negedge clk);
      if (!rst2 && q2.size() > 0) begin
        e = q2.pop_front();
        check("t6_pix_ce", k, pce2, 1);
        check("t6_hsync", k, hs2, e.hs);
        check("t6_active", k, act2, e.act);
        check("t6_frame_start", k, fs2, e.fs);
        k++;
      end
    end
  end

  initial begin
    int nr;
    exp_t e;
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < FT; p++) begin
        q.push_back(model(f * FT + p, p, fm[f]));
        for (int i = 0; i < 15; i++) begin
          if (pts[i].f == f && p == (pts[i].y + 5) * HT + pts[i].x + 7) begin
            e.idx = f * FT + p;
            e.hs = 1'b0; e.vs = 1'b0; e.act = 1'b1; e.fs = 1'b0;
            e.x = 12'(pts[i].x); e.y = 12'(pts[i].y); e.rgb = pts[i].rgb;
            q.push_back(e);
          end
        end
      end
    end
    for (int k = 0; k < 300; k++) begin
      int h, v;
      h = k % 14;
      v = (k / 14) % 8;
      e.idx = k;
      e.hs  = (h < 2) ? 1'b0 : 1'b1;
      e.act = (h >= 4) && (h < 12) && (v >= 4) && (v < 6);
      e.fs  = ((k % 112) == 0);
      e.vs = 1'b0; e.x = '0; e.y = '0; e.rgb = '0;
      q2.push_back(e);
    end

    repeat (3) @(negedge clk);
    check("rst_hsync", 0, hs, 0);
    check("rst_vsync", 0, vs, 0);
    check("rst_rgb", 0, {r, g, b}, 0);
    check("rst_active", 0, act, 0);
    check("rst_pix_ce", 0, pce, 0);
    check("rst_frame_start", 0, fs, 0);
    check("rst2_hsync", 0, hs2, 1);
    check("rst2_vsync", 0, vs2, 1);
    check("rst2_pix_ce", 0, pce2, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    rst2 = 1'b0;

    for (int f = 0; f < 4; f++) begin
      while (cyc < 2 * (f * FT + 20 * HT + 1)) @(negedge clk);
      mode = 2'(fm[f + 1]);
    end

    nr = 4 * FT + 30 * HT + 40;
    while (cyc < 2 * (nr + 1)) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_hsync", nr, hs, 0);
    check("async_vsync", nr, vs, 0);
    check("async_rgb", nr, {r, g, b}, 0);
    check("async_active", nr, act, 0);
    check("async_pix_x", nr, px, 0);
    check("async_pix_y", nr, py, 0);
    check("async_frame_start", nr, fs, 0);
    check("async_pix_ce", nr, pce, 0);
    check("queue_drained", nr, q.size(), 0);

    for (int p = 0; p < FT; p++) q.push_back(model(p, p, 0));
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;

    while (cyc < 2 * (FT + 5)) @(negedge clk);
    check("final_queue", 0, q.size(), 0);
    check("final_queue2", 0, q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
